apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 SHALL use one clock and a synchronous, active-high reset: pclk input 1, rising-edge clock; preset input 1, synchronous active-high reset.
REQ-005 SHALL have cmd_valid input 1, command request.
REQ-006 SHALL have cmd_ready output 1, command FIFO not full.
REQ-007 SHALL have cmd_write input 1, 1 = write, 0 = read.
REQ-008 SHALL have cmd_addr input ADDR_W and cmd_wdata input DATA_W, command address and write data.
REQ-009 SHALL have rsp_valid output 1, one-cycle completion pulse.
REQ-010 SHALL have rsp_rdata output DATA_W and rsp_slverr output 1, read data and error status for the completed transfer.
REQ-011 SHALL have APB requester outputs psel 1, penable 1, pwrite 1, paddr ADDR_W and pwdata DATA_W.
REQ-012 SHALL have APB completer inputs prdata DATA_W, pready 1 and pslverr 1.

Function
REQ-013 SHALL buffer commands in a 2-entry FIFO; a command is accepted on any edge where cmd_valid and cmd_ready are both high.
REQ-014 SHALL deassert cmd_ready only when the FIFO holds 2 entries; simultaneous push and pop when full SHALL be allowed.
REQ-015 SHALL implement states IDLE, SETUP and ACCESS.
REQ-016 SHALL move IDLE->SETUP when the FIFO is non-empty; a command accepted at edge N drives SETUP in cycle N+1.
REQ-017 SHALL drive psel=1, penable=0 and stable paddr/pwrite/pwdata in SETUP; SETUP lasts exactly one cycle and then moves to ACCESS.
REQ-018 SHALL drive psel=1 and penable=1 in ACCESS, holding all APB outputs stable while pready=0.
REQ-019 SHALL complete the transfer in an ACCESS cycle with pready=1, popping the FIFO and registering prdata and pslverr.
REQ-020 SHALL pulse rsp_valid in the cycle after completion; rsp_rdata SHALL be 0 for writes.
REQ-021 SHALL go ACCESS->SETUP on completion if another command is queued (back-to-back transfers, psel held high); otherwise ACCESS->IDLE with psel=0.
REQ-022 SHALL drive penable=0 whenever psel=0, and SHALL hold pwdata at its last value in IDLE.
REQ-023 SHALL have no response backpressure; responses are in command order.

Reset
REQ-024 SHALL, with preset high at an edge, enter IDLE, flush the FIFO, and drive psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_slverr to 0 and cmd_ready to 1, including mid-transfer; an aborted transfer SHALL produce no response.
REQ-025 SHALL ignore cmd_valid while preset is high.

Configuration
REQ-026 With APB_MASTER_TIMEOUT_EN defined: SHALL count ACCESS cycles, and if pready is still 0 on the TIMEOUT_CYCLES-th cycle, SHALL abort, pop the command, and pulse rsp_valid with rsp_slverr=1 and rsp_rdata=0.
REQ-027 Without APB_MASTER_TIMEOUT_EN: SHALL wait in ACCESS indefinitely and SHALL contain no timeout counter.

Structure
REQ-028 SHALL place the state enum (IDLE/SETUP/ACCESS) and the command struct (write, addr, wdata) in shared package apb_pkg.
REQ-029 SHALL implement the FIFO as sub-module apb_cmd_fifo (depth 2, payload = command struct).

Verification
REQ-030 Write then read: write 0x10 <- 0xDEADBEEF, then read 0x10 against apb_ram -> rsp_rdata=0xDEADBEEF and rsp_slverr=0; SETUP/ACCESS are each visible for one cycle when pready=1.
REQ-031 Wait states: pready held low for 3 ACCESS cycles -> APB outputs stable throughout, with rsp_valid exactly one cycle after the pready=1 cycle.
REQ-032 Back-to-back: 3 commands pushed on consecutive cycles -> cmd_ready low while 2 are queued, psel never drops between transfers, and 3 in-order responses.
REQ-033 Error: apb_ram asserts pslverr on an out-of-range address (e.g. 0x100) -> rsp_slverr=1.
REQ-034 Reset mid-ACCESS: preset pulsed while penable=1 -> psel=0 and cmd_ready=1 next cycle, with no rsp_valid.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=16): pready tied low -> rsp_valid with rsp_slverr=1 after 16 ACCESS cycles, then return to IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the queued command format.
// Command fields are stored at a fixed maximum width; ADDR_W/DATA_W must not exceed them.
package apb_pkg;

  localparam int CMD_ADDR_MAX = 64;
  localparam int CMD_DATA_MAX = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Two-entry command FIFO. Exposes both the head and the entry behind it so the
// requester can launch a back-to-back transfer on the same edge it pops the head.
module apb_cmd_fifo
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  apb_cmd_t   wdata,
  output apb_cmd_t   head,
  output apb_cmd_t   second,
  output logic [1:0] count,
  output logic       full
);

  apb_cmd_t   mem_r [2];
  logic       rd_ptr_r;
  logic       wr_ptr_r;
  logic [1:0] count_r;
  logic       do_push_s;
  logic       do_pop_s;

  // A pop frees the slot, so a push is still taken when full if it coincides with a pop.
  assign do_push_s = push & ((count_r != 2'd2) | pop);
  assign do_pop_s  = pop & (count_r != 2'd0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign head   = mem_r[rd_ptr_r];
  assign second = mem_r[~rd_ptr_r];
  assign count  = count_r;
  assign full   = (count_r == 2'd2);

endmodule

// File: rtl/apb_master.sv
// APB requester: queues commands in a 2-entry FIFO and runs IDLE/SETUP/ACCESS transfers.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state_r;
  apb_state_e state_next_s;
  apb_cmd_t   cmd_in_s;
  apb_cmd_t   head_s;
  apb_cmd_t   second_s;
  apb_cmd_t   load_cmd_s;
  logic [1:0] count_s;
  logic       full_s;
  logic       push_s;
  logic       pop_s;
  logic       done_s;
  logic       load_s;
  logic       timeout_s;
  logic       unused_bits_s;

  assign cmd_ready = ~full_s;
  assign push_s    = cmd_valid & ~full_s & ~preset;
  assign pop_s     = done_s;

  // Widen the incoming command into the package storage format.
  always_comb begin
    cmd_in_s                    = '0;
    cmd_in_s.write              = cmd_write;
    cmd_in_s.addr[ADDR_W-1:0]   = cmd_addr;
    cmd_in_s.wdata[DATA_W-1:0]  = cmd_wdata;
  end

  apb_cmd_fifo u_fifo (
    .clk    (pclk),
    .rst    (preset),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (cmd_in_s),
    .head   (head_s),
    .second (second_s),
    .count  (count_s),
    .full   (full_s)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // Counts stalled ACCESS cycles; zero on the first cycle of every ACCESS phase.
  always_ff @(posedge pclk) begin
    if (preset) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ACCESS) && !pready && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ACCESS) && !pready &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  assign done_s = (state_r == ACCESS) && (pready || timeout_s);

  // Next-state decode; load_s marks the edge that latches a new command onto the bus.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    load_cmd_s   = head_s;
    case (state_r)
      IDLE: begin
        if (count_s != 2'd0) begin
          state_next_s = SETUP;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
      end
      ACCESS: begin
        // The head is popped on this edge, so a queued follower is the second entry.
        if (done_s && (count_s == 2'd2)) begin
          state_next_s = SETUP;
          load_s       = 1'b1;
          load_cmd_s   = second_s;
        end else if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, bus outputs and the response register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r    <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      psel      <= (state_next_s != IDLE);
      penable   <= (state_next_s == ACCESS);
      rsp_valid <= done_s;
      if (load_s) begin
        pwrite <= load_cmd_s.write;
        paddr  <= load_cmd_s.addr[ADDR_W-1:0];
        pwdata <= load_cmd_s.wdata[DATA_W-1:0];
      end
      if (done_s) begin
        rsp_rdata  <= (pwrite || timeout_s) ? '0 : prdata;
        rsp_slverr <= timeout_s ? 1'b1 : pslverr;
      end
    end
  end

  assign unused_bits_s = ^{head_s, second_s};

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master against a small APB RAM completer.
// Timeout scenario runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_slverr;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // APB RAM completer: 64 words below 0x100, error above; programmable wait states.
  logic [31:0] mem [64];
  logic [7:0]  acc_cnt = 8'd0;
  logic [7:0]  wait_states = 8'd0;
  logic        stall = 1'b0;
  logic        ram_err;

  assign ram_err = (paddr >= 32'h100);
  assign pready  = psel & penable & ~stall & (acc_cnt >= wait_states);
  assign pslverr = ram_err;
  assign prdata  = ram_err ? 32'hBAD0BAD0 : mem[paddr[7:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 8'd1;
    else                            acc_cnt <= 8'd0;
    if (psel && penable && pready && pwrite && !ram_err) mem[paddr[7:2]] <= pwdata;
  end

  // Independent model of FIFO occupancy, used to predict cmd_ready.
  logic occ_chk_en = 1'b0;
  int   occ = 0;
  logic push_m, pop_m, tmo_hit;
`ifdef APB_MASTER_TIMEOUT_EN
  assign tmo_hit = psel & penable & ~pready & (acc_cnt == 8'd15);
`else
  assign tmo_hit = 1'b0;
`endif
  assign push_m = cmd_valid & cmd_ready & ~preset;
  assign pop_m  = psel & penable & (pready | tmo_hit);

  always @(posedge pclk) begin
    if (preset) occ <= 0;
    else        occ <= occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid.
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {rsp_rdata, rsp_slverr}, 33'h0);
        if (!({rsp_rdata, rsp_slverr} !== 33'h0)) begin
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp", {rsp_rdata, rsp_slverr}, {e.rdata, e.err});
      end
    end
  end

  // Protocol monitor: bus held stable through wait states, penable only with psel, cmd_ready.
  logic        prev_wait = 1'b0, prev_w = 1'b0, prev_psel = 1'b0;
  logic [31:0] prev_a = 32'h0, prev_d = 32'h0;
  logic        b2b_win = 1'b0;
  int          psel_falls = 0, rdy_low = 0;

  always @(negedge pclk) begin
    if (prev_wait === 1'b1 && psel === 1'b1)
      chk("access_hold", {penable, pwrite, paddr, pwdata}, {1'b1, prev_w, prev_a, prev_d});
    if (psel === 1'b0)
      chk("penable_needs_psel", penable, 1'b0);
    if (occ_chk_en)
      chk("cmd_ready_vs_occupancy", cmd_ready, (occ < 2));
    if (b2b_win) begin
      if (prev_psel && !psel) psel_falls <= psel_falls + 1;
      if (!cmd_ready)         rdy_low    <= rdy_low + 1;
    end
    prev_wait <= (psel === 1'b1) && (penable === 1'b1) && (pready === 1'b0);
    prev_w    <= pwrite;
    prev_a    <= paddr;
    prev_d    <= pwdata;
    prev_psel <= (psel === 1'b1);
  end

  task automatic align();
    @(posedge pclk); #1;
  endtask

  // Call at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input bit expect_rsp);
    bit acc = 1'b0;
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!acc && n < 50) begin
      @(negedge pclk); acc = cmd_ready;
      @(posedge pclk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", acc, 1'b1);
    if (acc && expect_rsp) exp_q.push_back('{rdata: er, err: ee});
  endtask

  task automatic phase_chk(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits);
    @(negedge pclk); chk("idle_before_setup", psel, 1'b0);
    @(negedge pclk); chk("setup", {psel, penable, pwrite, paddr, pwdata}, {2'b10, w, a, d});
    for (int i = 0; i <= waits; i++) begin
      @(negedge pclk);
      chk("access", {psel, penable, pwrite, paddr, pwdata, rsp_valid}, {2'b11, w, a, d, 1'b0});
    end
    @(negedge pclk); chk("rsp_after_ready", {rsp_valid, psel}, 2'b10);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || psel !== 1'b0) && n < 200) begin
      @(negedge pclk); n++;
    end
    chk("idle_reached", {(exp_q.size() != 0), psel}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    // Reset with a command offered: it must be ignored.
    preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h8; cmd_wdata = 32'h5555AAAA;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("reset_state", {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, cmd_ready},
        {3'b000, 64'h0, 1'b0, 32'h0, 1'b0, 1'b1});
    @(posedge pclk); #1;
    preset = 1'b0; cmd_valid = 1'b0;
    occ_chk_en = 1'b1;
    repeat (2) @(negedge pclk);
    chk("nothing_queued_in_reset", psel, 1'b0);

    // Write then read back, zero wait states.
    align();
    send(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    phase_chk(1'b1, 32'h10, 32'hDEADBEEF, 0);
    align();
    send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    phase_chk(1'b0, 32'h10, 32'h0, 0);
    chk("pwdata_held_idle", pwdata, 32'h0);

    // Three wait states.
    wait_states = 8'd3;
    align();
    send(1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    phase_chk(1'b1, 32'h14, 32'hCAFEF00D, 3);
    wait_states = 8'd0;
    chk("pwdata_held_after_write", pwdata, 32'hCAFEF00D);
    align();
    send(1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back: three commands offered on consecutive cycles.
    align();
    b2b_win = 1'b1;
    send(1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b1);
    send(1'b1, 32'h24, 32'h22222222, 32'h0, 1'b0, 1'b1);
    send(1'b0, 32'h24, 32'h0, 32'h22222222, 1'b0, 1'b1);
    wait_idle();
    @(negedge pclk);
    b2b_win = 1'b0;
    chk("b2b_psel_falls", psel_falls, 1);
    chk("b2b_ready_low_cycles", rdy_low, 3);

    // Completer error on out-of-range addresses.
    align();
    send(1'b0, 32'h100, 32'h0, 32'hBAD0BAD0, 1'b1, 1'b1);
    send(1'b1, 32'h104, 32'h77777777, 32'h0, 1'b1, 1'b1);
    wait_idle();

    // Reset pulsed mid-ACCESS: transfer aborted, no response.
    wait_states = 8'd5;
    align();
    send(1'b1, 32'h30, 32'h33333333, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (penable !== 1'b1 && n < 20) begin @(negedge pclk); n++; end
    chk("reached_access", penable, 1'b1);
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("reset_abort", {psel, penable, cmd_ready, rsp_valid, paddr, pwdata}, {4'b0010, 64'h0});
    repeat (6) @(negedge pclk);
    wait_states = 8'd0;
    align();
    send(1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1'b1);
    wait_idle();

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never ready: abort after 16 ACCESS cycles with slverr.
    stall = 1'b1;
    align();
    send(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) break;
      if (penable === 1'b1) n++;
    end
    chk("timeout_access_cycles", n, 16);
    chk("timeout_back_to_idle", {rsp_valid, psel}, 2'b10);
    stall = 1'b0;
    wait_idle();
`endif

    repeat (2) @(negedge pclk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
